// File: rtl/byte_unstripping_n.sv
// Buffers striped multi-lane words and replays their valid bytes one per cycle, in word order then ascending lane.
// Latency: 1 cycle from accept into an empty buffer to data_demux; in_ready drops when full, output holds while out_ready=0.
module byte_unstripping_n #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       clk_f,
   input  logic                       reset,
   input  logic [LANES*DATA_W-1:0]    data_stripe,
   input  logic [LANES-1:0]           valid_stripe,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          data_demux,
   output logic                       valid_demux,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       err_pattern
);

   localparam int LW = $clog2(LANES);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   logic [LANES*DATA_W-1:0] dat_mem [DEPTH];
   logic [LANES-1:0]        msk_mem [DEPTH];

   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             fill;
   logic [LW-1:0]           lane_ptr;
   logic                    rdy_q;

   logic [LANES*DATA_W-1:0] head_dat;
   logic [LANES-1:0]        head_msk, higher, next_msk;
   logic                    last, push, xfer, pop;

   function automatic logic [LW-1:0] first_lane(input logic [LANES-1:0] m);
      first_lane = '0;
      for (int k = LANES-1; k >= 0; k--)
         if (m[k]) first_lane = LW'(k);
   endfunction

   function automatic logic contiguous(input logic [LANES-1:0] m);
      contiguous = ((m & (m + LANES'(1))) == '0);
   endfunction

   always_comb begin
      head_dat    = dat_mem[rd_ptr];
      head_msk    = msk_mem[rd_ptr];
      // Lanes strictly above lane_ptr that are still valid in the head word.
      higher      = head_msk & ~((LANES'(2) << lane_ptr) - LANES'(1));
      last        = (higher == '0);
      valid_demux = (fill != '0);
      data_demux  = valid_demux ? head_dat[int'(lane_ptr)*DATA_W +: DATA_W] : '0;
      in_ready    = rdy_q && (fill != FULL);
      push        = (|valid_stripe) && in_ready;
      xfer        = valid_demux && out_ready;
      pop         = xfer && last;
      // The word that becomes head after a pop: already buffered, or arriving now.
      next_msk    = (fill > ONE) ? msk_mem[rd_ptr + AW'(1)] : valid_stripe;
      fill_level  = fill;
   end

   always_ff @(posedge clk_f) begin
      if (push) begin
         dat_mem[wr_ptr] <= data_stripe;
         msk_mem[wr_ptr] <= valid_stripe;
      end
   end

   always_ff @(posedge clk_f or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill        <= '0;
         lane_ptr    <= '0;
         err_pattern <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!contiguous(valid_stripe)) err_pattern <= 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + ONE;
            2'b01:   fill <= fill - ONE;
            default: fill <= fill;
         endcase
         if (!valid_demux && push)
            lane_ptr <= first_lane(valid_stripe);
         else if (pop) begin
            if ((fill > ONE) || push) lane_ptr <= first_lane(next_msk);
         end else if (xfer)
            lane_ptr <= first_lane(higher);
      end
   end

endmodule

// File: tb/tb_byte_unstripping_n.sv
// Randomized and directed bench: a byte-queue reference model is updated per edge and a monitor compares every cycle.
module tb_byte_unstripping_n;
   localparam int DW = 8;
   localparam int LN = 4;
   localparam int DP = 4;

   logic             clk_f = 1'b0;
   logic             reset = 1'b1;
   logic [LN*DW-1:0] data_stripe = '0;
   logic [LN-1:0]    valid_stripe = '0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic [DW-1:0]    data_demux;
   logic             valid_demux;
   logic [2:0]       fill_level;
   logic             err_pattern;

   byte_unstripping_n #(.DATA_W(DW), .LANES(LN), .DEPTH(DP)) dut (
      .clk_f(clk_f), .reset(reset), .data_stripe(data_stripe), .valid_stripe(valid_stripe),
      .in_ready(in_ready), .data_demux(data_demux), .valid_demux(valid_demux),
      .out_ready(out_ready), .fill_level(fill_level), .err_pattern(err_pattern));

   always #5 clk_f = ~clk_f;

   int tests = 0;
   int fails = 0;

   // Reference model: expected output bytes, plus bytes remaining per buffered word.
   logic [DW-1:0] exp_q[$];
   int            wl_q[$];
   bit            rdy_m = 1'b0;
   bit            err_m = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_f) begin
      bit accept;
      int n;
      if (reset) begin
         check("rst_valid", valid_demux, 0);
         check("rst_data", data_demux, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_fill", fill_level, 0);
         check("rst_err", err_pattern, 0);
         exp_q.delete();
         wl_q.delete();
         rdy_m = 1'b0;
         err_m = 1'b0;
      end else begin
         check("valid_demux", valid_demux, wl_q.size() != 0);
         check("fill_level", fill_level, wl_q.size());
         check("in_ready", in_ready, rdy_m && (wl_q.size() < DP));
         check("err_pattern", err_pattern, err_m);
         if (wl_q.size() != 0) check("data_demux", data_demux, exp_q[0]);
         accept = (valid_stripe != 0) && rdy_m && (wl_q.size() < DP);
         if (wl_q.size() != 0 && out_ready) begin
            void'(exp_q.pop_front());
            wl_q[0] = wl_q[0] - 1;
            if (wl_q[0] == 0) void'(wl_q.pop_front());
         end
         if (accept) begin
            n = $countones(valid_stripe);
            for (int k = 0; k < LN; k++)
               if (valid_stripe[k]) exp_q.push_back(data_stripe[k*DW +: DW]);
            wl_q.push_back(n);
            if (int'(valid_stripe) != (1 << n) - 1) err_m = 1'b1;
         end
         rdy_m = 1'b1;
      end
   end

   // Callers are always positioned 1 time unit after a rising edge.
   task automatic put(input logic [LN*DW-1:0] d, input logic [LN-1:0] v);
      data_stripe  = d;
      valid_stripe = v;
      @(posedge clk_f); #1;
      valid_stripe = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_f); #1;
      end
   endtask

   initial begin
      idle(2);
      reset = 1'b0;
      idle(1);

      // Full word streams out lane by lane.
      out_ready = 1'b1;
      put(32'h44332211, 4'hF);
      idle(6);

      // Partial then full word, back to back.
      put(32'h0000BBAA, 4'h3);
      put(32'h04030201, 4'hF);
      idle(8);

      // Fill while stalled; fifth word must be dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) put($urandom, 4'hF);
      idle(1);
      check("fill_when_full", fill_level, 4);
      check("in_ready_when_full", in_ready, 0);
      out_ready = 1'b1;
      idle(20);

      // Non-contiguous mask: bytes 0A, 0C only; error sticks.
      put(32'h0D0C0B0A, 4'b0101);
      idle(4);
      check("err_sticky", err_pattern, 1);

      // Toggling out_ready mid-word.
      put(32'h88776655, 4'hF);
      for (int i = 0; i < 8; i++) begin
         out_ready = ~out_ready;
         idle(1);
      end
      out_ready = 1'b1;
      idle(4);

      // Reset after two bytes of a word have gone out.
      put(32'hDDCCBBAA, 4'hF);
      idle(2);
      reset = 1'b1;
      #1;
      check("async_rst_valid", valid_demux, 0);
      check("async_rst_data", data_demux, 0);
      check("async_rst_fill", fill_level, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_err", err_pattern, 0);
      idle(2);
      reset = 1'b0;
      idle(3);
      check("no_residue_after_reset", valid_demux, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) idle(1);
         else put($urandom, LN'($urandom_range(0, 15)));
      end

      out_ready = 1'b1;
      for (int i = 0; i < 100 && valid_demux; i++) idle(1);
      check("drained", valid_demux, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
